alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (4-bit op code, two WIDTH operands, result plus Zero flag) between two requesters, e.g. the main datapath and an address/branch helper unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, registers the operands into the ALU, captures result and Zero, and holds the response until it is accepted.
- One operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- CTLW, 4, ALU control code width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_ctl  in  CTLW  ALU op code (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 11 LUI, 12 NOR)
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 takes the result
- resp0_data  out  WIDTH  result
- resp0_zero  out  1  Zero flag of the result
- req1_* / resp1_*  same set and meaning for requester 1
- alu_ctl  out  CTLW  registered op code to the ALU
- alu_a  out  WIDTH  registered operand A to the ALU
- alu_b  out  WIDTH  registered operand B to the ALU
- alu_out  in  WIDTH  ALU result (combinational from alu_ctl/alu_a/alu_b)
- alu_zero  in  1  ALU Zero flag

Behaviour:
- Reset: applies immediately on rst_n low, independent of clk.
  - State is IDLE.
  - All ready/valid outputs are 0; alu_ctl, alu_a, alu_b, resp*_data and resp*_zero are 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - An in-flight operation or pending response is discarded. A requester whose op is lost must reissue it.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Grant selection:
    - If only one reqN_valid is high, that requester is granted.
    - If both are high, grant goes to the requester that is not last_grant.
  - reqN_ready = 1 combinationally for the granted requester only; it is 0 in EXEC and RESP.
  - On the edge where reqN_valid && reqN_ready:
    - alu_ctl/alu_a/alu_b are loaded from reqN_*.
    - owner is set to N and last_grant is set to N.
    - The FSM moves to EXEC.
- EXEC:
  - Exactly one cycle; alu_* are held stable.
  - At the end of the cycle, alu_out -> respN_data and alu_zero -> respN_zero for the owner only.
  - The FSM moves to RESP.
- RESP:
  - resp<owner>_valid = 1; the other resp valid stays 0.
  - data/zero are held stable while valid && !ready.
  - On the edge where valid && ready, the FSM goes to IDLE. The next grant is evaluated in that IDLE cycle, not in the same cycle.
- Latency: the accept edge is cycle 0, the result is registered at cycle 1, and respN_valid is high from cycle 2. Minimum issue interval is 3 cycles.
- Holding values:
  - resp*_data/zero keep their last values after acceptance; they are not cleared.
  - alu_* hold their last operation until the next accept.
- Data integrity:
  - Opcode passthrough: undefined codes are forwarded unchanged. The arbiter does not inspect or alter data; it only stores alu_out/alu_zero.
  - Requester inputs may change freely when ready is 0; only the values at the accept edge matter.
  - A requester dropping valid before it is granted is legal. No op is issued for it.
- Fairness: continuous requests from both sides alternate strictly 0,1,0,1… Neither requester waits more than one operation.

Optional Feature:
- Macro: ALU_ARB_STATS_EN
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each 16 bits, plus input stats_clr.
  - A counter increments on each accept edge of its requester and wraps 0xFFFF -> 0x0000.
  - stats_clr (synchronous) zeroes both counters and has priority over an increment in the same cycle.
  - Counters reset to 0 on rst_n.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single add: req0 ctl=2, a=5, b=7, resp0_ready=1 -> req0_ready at cycle 0; resp0_valid at cycle 2 with data=12, zero=0; resp1_valid stays 0.
- Tie and alternation: both valid every cycle, req0 SUB 9-9, req1 NOR 0,0 -> grant order 0,1,0,1. req0 gets data=0, zero=1. req1 gets data=0xFFFFFFFF, zero=0.
- Response backpressure: req1 LUI b=0x0003, resp1_ready low for 5 cycles -> data=0x00030000 held stable with valid=1 throughout. No new grant, even with req0_valid=1, until the accept edge.
- SLT and undefined op: req0 ctl=7, a=3, b=4 -> data=1. Then ctl=5 -> data=0, zero=1, with alu_ctl observed as 5.
- Reset mid-operation: assert rst_n low during EXEC -> all outputs 0 asynchronously. After release, the FSM is in IDLE and a retried req1 op completes normally.
- Stats (ALU_ARB_STATS_EN): 3 req0 ops and 2 req1 ops -> grant_cnt0=3, grant_cnt1=2. stats_clr pulsed in the same cycle as an accept -> counter reads 0. Preload 0xFFFF and do one accept -> counter reads 0.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arbiter_if
// Brief   : Request/response channels of both requesters plus the shared ALU bus.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CTLW  = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [CTLW-1:0]  req0_ctl;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             resp0_valid;
  logic             resp0_ready;
  logic [WIDTH-1:0] resp0_data;
  logic             resp0_zero;

  logic             req1_valid;
  logic             req1_ready;
  logic [CTLW-1:0]  req1_ctl;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             resp1_valid;
  logic             resp1_ready;
  logic [WIDTH-1:0] resp1_data;
  logic             resp1_zero;

  logic [CTLW-1:0]  alu_ctl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b, resp0_ready,
    input  req1_valid, req1_ctl, req1_a, req1_b, resp1_ready,
    input  alu_out, alu_zero,
    output req0_ready, resp0_valid, resp0_data, resp0_zero,
    output req1_ready, resp1_valid, resp1_data, resp1_zero,
    output alu_ctl, alu_a, alu_b
  );

  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b, resp0_ready,
    output req1_valid, req1_ctl, req1_a, req1_b, resp1_ready,
    output alu_out, alu_zero,
    input  req0_ready, resp0_valid, resp0_data, resp0_zero,
    input  req1_ready, resp1_valid, resp1_data, resp1_zero,
    input  alu_ctl, alu_a, alu_b
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Round-robin sharing of one combinational ALU between two requesters.
//           Optional grant counters enabled by macro ALU_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTLW  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ALU_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
`endif
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [CTLW-1:0]  alu_ctl_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             resp0_valid_q;
  logic             resp1_valid_q;
  logic [WIDTH-1:0] resp0_data_q;
  logic [WIDTH-1:0] resp1_data_q;
  logic             resp0_zero_q;
  logic             resp1_zero_q;

  logic             grant_any_d;
  logic             grant_sel_d;
  logic             resp_take_d;

  // Ready is gated by rst_n so no handshake can complete while reset is held.
  always_comb begin
    grant_any_d = 1'b0;
    grant_sel_d = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_any_d = 1'b1;
        grant_sel_d = ~last_grant_q;
      end else if (bus.req0_valid) begin
        grant_any_d = 1'b1;
      end else if (bus.req1_valid) begin
        grant_any_d = 1'b1;
        grant_sel_d = 1'b1;
      end
    end
  end

  assign resp_take_d = owner_q ? bus.resp1_ready : bus.resp0_ready;

  assign bus.req0_ready  = grant_any_d & ~grant_sel_d;
  assign bus.req1_ready  = grant_any_d &  grant_sel_d;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp0_data  = resp0_data_q;
  assign bus.resp1_data  = resp1_data_q;
  assign bus.resp0_zero  = resp0_zero_q;
  assign bus.resp1_zero  = resp1_zero_q;
  assign bus.alu_ctl     = alu_ctl_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      alu_ctl_q     <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
      resp0_zero_q  <= 1'b0;
      resp1_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any_d) begin
            state_q      <= EXEC;
            owner_q      <= grant_sel_d;
            last_grant_q <= grant_sel_d;
            alu_ctl_q    <= grant_sel_d ? bus.req1_ctl : bus.req0_ctl;
            alu_a_q      <= grant_sel_d ? bus.req1_a   : bus.req0_a;
            alu_b_q      <= grant_sel_d ? bus.req1_b   : bus.req0_b;
          end
        end
        EXEC: begin
          state_q <= RESP;
          if (owner_q) begin
            resp1_data_q  <= bus.alu_out;
            resp1_zero_q  <= bus.alu_zero;
            resp1_valid_q <= 1'b1;
          end else begin
            resp0_data_q  <= bus.alu_out;
            resp0_zero_q  <= bus.alu_zero;
            resp0_valid_q <= 1'b1;
          end
        end
        RESP: begin
          // Data/zero registers are left untouched so they keep the last result.
          if (resp_take_d) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0_q;
  logic [15:0] grant_cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q <= 16'h0000;
      grant_cnt1_q <= 16'h0000;
    end else if (stats_clr) begin
      grant_cnt0_q <= 16'h0000;
      grant_cnt1_q <= 16'h0000;
    end else begin
      if (grant_any_d && !grant_sel_d) grant_cnt0_q <= grant_cnt0_q + 16'd1;
      if (grant_any_d &&  grant_sel_d) grant_cnt1_q <= grant_cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
`default_nettype wire
